// File: rtl/machine_ctl.sv
// Instruction-cycle sequencer for the 8-bit accumulator CPU: steps an
// 8-phase micro-sequence per instruction, decodes control strobes, counts retired instructions.
module machine_ctl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_acc,
  output logic             load_ir,
  output logic             rd,
  output logic             wr,
  output logic             datactl_ena,
  output logic             halt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic               is_alu;
  logic               is_skz, is_sto, is_jmp;

  assign is_alu = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                  (opcode == OP_XORR) || (opcode == OP_LDA);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  // State and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Next-state: wait for fetch, then free-run until reset; HLT diverts after S3.
  always_comb begin
    state_d     = state_q;
    instr_cnt_d = instr_cnt_q;
    case (state_q)
      ST_IDLE:   if (fetch) state_d = ST_S0;
      ST_S0:     state_d = ST_S1;
      ST_S1:     state_d = ST_S2;
      ST_S2:     state_d = ST_S3;
      ST_S3:     state_d = (opcode == OP_HLT) ? ST_HALTED : ST_S4;
      ST_S4:     state_d = ST_S5;
      ST_S5:     state_d = ST_S6;
      ST_S6:     state_d = ST_S7;
      ST_S7: begin
        state_d     = ST_S0;
        instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobe decode from current phase, opcode and live zero flag.
  always_comb begin
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    load_ir     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    case (state_q)
      ST_S0: begin
        rd      = 1'b1;
        load_ir = 1'b1;
      end
      ST_S1: begin
        rd      = 1'b1;
        load_ir = 1'b1;
        inc_pc  = 1'b1;
      end
      ST_S3: inc_pc = 1'b1;
      ST_S4: begin
        rd          = is_alu;
        load_pc     = is_jmp;
        datactl_ena = is_sto;
      end
      ST_S5: begin
        rd          = is_alu;
        load_acc    = is_alu;
        inc_pc      = (is_skz && zero) || is_jmp;
        load_pc     = is_jmp;
        wr          = is_sto;
        datactl_ena = is_sto;
      end
      ST_S6: begin
        rd          = is_alu;
        datactl_ena = is_sto;
      end
      ST_S7:     inc_pc = is_skz && zero;
      ST_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_machine_ctl.sv
// Scoreboard bench for machine_ctl: per-phase strobe expectations are queued
// when an instruction is issued and popped as each phase is observed.
module tb_machine_ctl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, fetch, zero;
  logic [2:0]       opcode;
  logic             inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;
  logic [CNT_W-1:0] instr_cnt;
  logic [7:0]       strobes;
  logic [7:0]       exp_s;
  logic [CNT_W-1:0] exp_cnt;
  logic [7:0]       sb_q [$];
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  machine_ctl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc), .load_ir(load_ir),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .instr_cnt(instr_cnt)
  );

  // {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena}
  assign strobes = {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena};

  // Full 8-phase table: common fetch phases S0..S3 plus opcode-specific S4..S7.
  function automatic logic [63:0] mk(input logic [7:0] s4, input logic [7:0] s5,
                                     input logic [7:0] s6, input logic [7:0] s7);
    return {s7, s6, s5, s4, 8'h40, 8'h00, 8'h4C, 8'h0C};
  endfunction

  task automatic push_instr(input logic [2:0] op, input logic [63:0] tbl, input int n);
    opcode = op;
    for (int i = 0; i < n; i++) sb_q.push_back(tbl[i*8 +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b0; fetch = 1'b1; opcode = 3'b000; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (strobes !== 8'h00 || instr_cnt !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d strobes=%b cnt=%0d exp strobes=00000000 cnt=0", i, strobes, instr_cnt);
      end
    end
    reset = 1'b1; fetch = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (strobes !== 8'h00) begin
        errors++;
        $display("FAIL idle cyc %0d strobes=%b exp=00000000", i, strobes);
      end
    end
    fetch = 1'b1;
    @(negedge clk); #1;
    fetch = 1'b0;
    checks++;
    if (strobes !== 8'h0C) begin
      errors++;
      $display("FAIL fetch_to_s0 strobes=%b exp=00001100", strobes);
    end
    exp_cnt = '0;
  endtask

  task automatic test_lda();
    push_instr(3'b101, mk(8'h04, 8'h14, 8'h04, 8'h00), 8);
    for (int p = 0; p < 8; p++) begin
      zero = 1'(p & 1); #1;
      exp_s = sb_q.pop_front();
      checks++;
      if (strobes !== exp_s) begin
        errors++;
        $display("FAIL lda phase %0d strobes=%b exp=%b", p, strobes, exp_s);
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 4'd1;
    #1; checks++;
    if (instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL lda_retire cnt=%0d exp=%0d", instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_sto_jmp();
    logic [2:0]  ops  [2];
    logic [63:0] tbls [2];
    ops[0] = 3'b110; tbls[0] = mk(8'h01, 8'h03, 8'h01, 8'h00);
    ops[1] = 3'b111; tbls[1] = mk(8'h20, 8'h60, 8'h00, 8'h00);
    for (int k = 0; k < 2; k++) begin
      push_instr(ops[k], tbls[k], 8);
      for (int p = 0; p < 8; p++) begin
        zero = 1'b1; #1;
        exp_s = sb_q.pop_front();
        checks++;
        if (strobes !== exp_s || (p == 0 && instr_cnt !== exp_cnt)) begin
          errors++;
          $display("FAIL sto_jmp op %b phase %0d strobes=%b cnt=%0d exp strobes=%b cnt=%0d",
                   ops[k], p, strobes, instr_cnt, exp_s, exp_cnt);
        end
        @(negedge clk);
      end
      exp_cnt = exp_cnt + 4'd1;
    end
  endtask

  task automatic test_skz();
    logic [7:0]  zpat [4];
    logic [63:0] tbls [4];
    zpat[0] = 8'hFF; tbls[0] = mk(8'h00, 8'h40, 8'h00, 8'h40);
    zpat[1] = 8'h00; tbls[1] = mk(8'h00, 8'h00, 8'h00, 8'h00);
    zpat[2] = 8'h20; tbls[2] = mk(8'h00, 8'h40, 8'h00, 8'h00);
    zpat[3] = 8'h80; tbls[3] = mk(8'h00, 8'h00, 8'h00, 8'h40);
    for (int k = 0; k < 4; k++) begin
      push_instr(3'b001, tbls[k], 8);
      for (int p = 0; p < 8; p++) begin
        zero = zpat[k][p]; #1;
        exp_s = sb_q.pop_front();
        checks++;
        if (strobes !== exp_s || (p == 0 && instr_cnt !== exp_cnt)) begin
          errors++;
          $display("FAIL skz run %0d phase %0d strobes=%b cnt=%0d exp strobes=%b cnt=%0d",
                   k, p, strobes, instr_cnt, exp_s, exp_cnt);
        end
        @(negedge clk);
      end
      exp_cnt = exp_cnt + 4'd1;
    end
  endtask

  task automatic test_hlt();
    push_instr(3'b000, mk(8'h00, 8'h00, 8'h00, 8'h00), 4);
    for (int i = 0; i < 20; i++) sb_q.push_back(8'h80);
    for (int p = 0; p < 24; p++) begin
      fetch = 1'(p & 1); zero = 1'(p & 2); #1;
      exp_s = sb_q.pop_front();
      checks++;
      if (strobes !== exp_s || instr_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL hlt cyc %0d strobes=%b cnt=%0d exp strobes=%b cnt=%0d",
                 p, strobes, instr_cnt, exp_s, exp_cnt);
      end
      @(negedge clk);
    end
    reset = 1'b0; fetch = 1'b0;
    @(negedge clk); #1;
    exp_cnt = '0;
    checks++;
    if (strobes !== 8'h00 || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL hlt_reset strobes=%b cnt=%0d exp strobes=00000000 cnt=0", strobes, instr_cnt);
    end
    reset = 1'b1; fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_instr(3'b100, mk(8'h04, 8'h14, 8'h04, 8'h00), 8);
    for (int p = 0; p < 8; p++) begin
      zero = 1'b0; #1;
      exp_s = sb_q.pop_front();
      checks++;
      if (strobes !== exp_s || (p == 0 && instr_cnt !== exp_cnt)) begin
        errors++;
        $display("FAIL xorr phase %0d strobes=%b cnt=%0d exp strobes=%b cnt=%0d",
                 p, strobes, instr_cnt, exp_s, exp_cnt);
      end
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 4'd1;
    push_instr(3'b010, mk(8'h04, 8'h14, 8'h04, 8'h00), 6);
    for (int p = 0; p < 6; p++) begin
      #1;
      exp_s = sb_q.pop_front();
      checks++;
      if (strobes !== exp_s || (p == 0 && instr_cnt !== exp_cnt)) begin
        errors++;
        $display("FAIL add_partial phase %0d strobes=%b cnt=%0d exp strobes=%b cnt=%0d",
                 p, strobes, instr_cnt, exp_s, exp_cnt);
      end
      if (p < 5) @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    exp_cnt = '0;
    checks++;
    if (strobes !== 8'h00 || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL mid_reset strobes=%b cnt=%0d exp strobes=00000000 cnt=0", strobes, instr_cnt);
    end
    reset = 1'b1; fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0]  ops  [4];
    logic [63:0] tbls [4];
    ops[0] = 3'b010; tbls[0] = mk(8'h04, 8'h14, 8'h04, 8'h00);
    ops[1] = 3'b011; tbls[1] = mk(8'h04, 8'h14, 8'h04, 8'h00);
    ops[2] = 3'b110; tbls[2] = mk(8'h01, 8'h03, 8'h01, 8'h00);
    ops[3] = 3'b111; tbls[3] = mk(8'h20, 8'h60, 8'h00, 8'h00);
    for (int n = 0; n < 16; n++) begin
      push_instr(ops[n % 4], tbls[n % 4], 8);
      for (int p = 0; p < 8; p++) begin
        zero = 1'($urandom_range(0, 1)); #1;
        exp_s = sb_q.pop_front();
        checks++;
        if (strobes !== exp_s || (p == 0 && instr_cnt !== exp_cnt)) begin
          errors++;
          $display("FAIL wrap instr %0d phase %0d strobes=%b cnt=%0d exp strobes=%b cnt=%0d",
                   n, p, strobes, instr_cnt, exp_s, exp_cnt);
        end
        @(negedge clk);
      end
      exp_cnt = exp_cnt + 4'd1;
    end
    #1; checks++;
    if (instr_cnt !== 4'd0 || instr_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL wrap_to_zero cnt=%0d exp=0", instr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sto_jmp();
    test_skz();
    test_hlt();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
